multiplier_datapath_taint_track_bitwise: RTL

Datapath for the sequential shift-add multiplier, with bitwise taint tracking. It sits directly downstream of the multiplier control FSM. It consumes that FSM's register-control strobes (mdld, mrld, rsclear, rsload, rsshr, productDone) and their taint bits. It returns the multiplier register, and its per-bit taint, so the FSM can select the bit tested in each add step. Every architectural register carries a shadow `_t` register, updated under the conservative bitwise rules below.

---
 rtl/multiplier_datapath_taint_track_bitwise.sv | 115 +++++++++++
 1 files changed

// File: rtl/multiplier_datapath_taint_track_bitwise.sv
// Shift-add multiplier datapath with bitwise taint shadows on every register.
// Control strobes come from the multiplier FSM; taint composes through each priority mux stage.
module multiplier_datapath_taint_track_bitwise #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplicand_t,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic [WIDTH-1:0]   multiplier_t,
   input  logic               mdld,
   input  logic               mdld_t,
   input  logic               mrld,
   input  logic               mrld_t,
   input  logic               rsclear,
   input  logic               rsclear_t,
   input  logic               rsload,
   input  logic               rsload_t,
   input  logic               rsshr,
   input  logic               rsshr_t,
   input  logic               productDone,
   input  logic               productDone_t,
   output logic [WIDTH-1:0]   multiplierReg,
   output logic [WIDTH-1:0]   multiplierReg_t,
   output logic [2*WIDTH-1:0] product,
   output logic [2*WIDTH-1:0] product_t,
   output logic               product_valid,
   output logic               product_valid_t
);

   localparam int PW = 2 * WIDTH;

   logic [WIDTH-1:0] md, md_t;
   logic             carry, carry_t;

   logic [WIDTH-1:0] md_n, md_tn, mr_n, mr_tn;
   logic [PW:0]      acc, acc_t;
   logic [PW:0]      sh_v, sh_t, s1_v, s1_t;
   logic [PW:0]      add_v, add_t, s2_v, s2_t;
   logic [PW:0]      s3_v, s3_t;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   sum_t;
   logic             pre_t;
   logic             vd_v, vd_t, v_n, v_tn;

   always_comb begin
      md_n  = mdld ? multiplicand : md;
      md_tn = mdld_t ? (multiplicand_t | md_t | (multiplicand ^ md))
                     : (mdld ? multiplicand_t : md_t);
      mr_n  = mrld ? multiplier : multiplierReg;
      mr_tn = mrld_t ? (multiplier_t | multiplierReg_t | (multiplier ^ multiplierReg))
                     : (mrld ? multiplier_t : multiplierReg_t);
   end

   // Running sum plus carry treated as one (2W+1)-bit word through the mux chain.
   always_comb begin
      acc   = {carry, product};
      acc_t = {carry_t, product_t};

      sh_v = {1'b0, carry, product[PW-1:1]};
      sh_t = {1'b0, carry_t, product_t[PW-1:1]};
      s1_v = rsshr ? sh_v : acc;
      s1_t = rsshr_t ? (sh_t | acc_t | (sh_v ^ acc)) : (rsshr ? sh_t : acc_t);

      sum   = {1'b0, product[PW-1:WIDTH]} + {1'b0, md};
      sum_t = '0;
      pre_t = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         pre_t    = pre_t | product_t[WIDTH+i] | md_t[i];
         sum_t[i] = pre_t;
      end
      sum_t[WIDTH] = pre_t;
      add_v = {sum, product[WIDTH-1:0]};
      add_t = {sum_t, product_t[WIDTH-1:0]};
      s2_v  = rsload ? add_v : s1_v;
      s2_t  = rsload_t ? (add_t | s1_t | (add_v ^ s1_v)) : (rsload ? add_t : s1_t);

      s3_v = rsclear ? '0 : s2_v;
      s3_t = rsclear_t ? (s2_t | s2_v) : (rsclear ? '0 : s2_t);
   end

   always_comb begin
      vd_v = productDone ? 1'b1 : product_valid;
      vd_t = productDone_t ? (product_valid_t | ~product_valid)
                           : (productDone ? 1'b0 : product_valid_t);
      v_n  = mdld ? 1'b0 : vd_v;
      v_tn = mdld_t ? (vd_t | vd_v) : (mdld ? 1'b0 : vd_t);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         md              <= '0;
         md_t            <= '0;
         multiplierReg   <= '0;
         multiplierReg_t <= '0;
         product         <= '0;
         product_t       <= '0;
         carry           <= 1'b0;
         carry_t         <= 1'b0;
         product_valid   <= 1'b0;
         product_valid_t <= 1'b0;
      end else begin
         md              <= md_n;
         md_t            <= md_tn;
         multiplierReg   <= mr_n;
         multiplierReg_t <= mr_tn;
         {carry, product}     <= s3_v;
         {carry_t, product_t} <= s3_t;
         product_valid   <= v_n;
         product_valid_t <= v_tn;
      end
   end

endmodule
